// File: rtl/uart_rx_bridge_if.sv
// Consumer-side byte handshake between the UART receiver and the Wrapper.
// The receiver drives head byte and valid; the consumer answers with ack.
interface uart_rx_bridge_if;
    logic [7:0] UART_RX;
    logic       UART_RX_valid;
    logic       UART_RX_ack;

    modport master (
        output UART_RX,
        output UART_RX_valid,
        input  UART_RX_ack
    );

    modport slave (
        input  UART_RX,
        input  UART_RX_valid,
        output UART_RX_ack
    );
endinterface

// File: rtl/uart_rx_bridge.sv
// 8N1 UART receiver feeding a small byte FIFO with a valid/ack consumer port.
// Framing errors and overruns are reported as one-cycle registered pulses.
module uart_rx_bridge #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              RX,
    uart_rx_bridge_if.master  rx_if,
    output logic              RX_frame_err,
    output logic              RX_overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [AW:0]   P_ONE   = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          sync_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic          frame_err_q;
    logic          overrun_q;

    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic tick_half;
    logic tick_bit;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic accept;

    assign tick_half = (timer_q == HALF_M1);
    assign tick_bit  = (timer_q == FULL_M1);
    assign push      = (state_q == STOP) && tick_bit && rx_s_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= RX;
            rx_s_q    <= sync_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Timer counts from 0 on the cycle after each state entry or sample.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    timer_q   <= '0;
                    bit_idx_q <= '0;
                    if (rx_prev_q && !rx_s_q) state_q <= START;
                end
                START: begin
                    if (tick_half) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s_q ? IDLE : DATA;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        timer_q     <= '0;
                        frame_err_q <= !rx_s_q;
                        state_q     <= IDLE;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop    = rx_if.UART_RX_ack && !empty;
    assign accept = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = wr_ptr_q + P_ONE;
        if (pop)    rd_ptr_d = rd_ptr_q + P_ONE;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= push && full && !pop;
        end
    end

    // Storage needs no reset: empty entries are masked on the output.
    always_ff @(posedge CLK) begin
        if (accept) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    assign rx_if.UART_RX       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign rx_if.UART_RX_valid = !empty;
    assign RX_frame_err        = frame_err_q;
    assign RX_overrun          = overrun_q;

endmodule
